// File: rtl/adder_share_pkg.sv
// Shared types and opcode constants for the arbitrated shared-adder block.
package adder_share_pkg;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_ACC  = 2'b01;
    localparam logic [1:0] OP_CLR  = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef logic req_id_t;

endpackage

// File: rtl/add_unit.sv
// Combinational adder datapath: computes result, carry and accumulator update for one op.
module add_unit
    import adder_share_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] acc_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             acc_we_o,
    output logic [WIDTH-1:0] acc_next_o
);

    logic [WIDTH:0] full_c;

    // Zero-extend operands by one bit so the MSB of the result is the carry-out.
    always_comb begin
        full_c     = '0;
        acc_we_o   = 1'b0;
        acc_next_o = '0;
        case (op_i)
            OP_ADD: begin
                full_c = {1'b0, a_i} + {1'b0, b_i};
            end
            OP_ACC: begin
                full_c     = {1'b0, acc_i} + {1'b0, a_i};
                acc_we_o   = 1'b1;
                acc_next_o = full_c[WIDTH-1:0];
            end
            OP_CLR: begin
                full_c     = '0;
                acc_we_o   = 1'b1;
                acc_next_o = '0;
            end
            default: begin
                full_c     = {1'b0, a_i};
                acc_we_o   = 1'b1;
                acc_next_o = a_i;
            end
        endcase
        sum_o   = full_c[WIDTH-1:0];
        carry_o = full_c[WIDTH];
    end

endmodule

// File: rtl/adder_share_arb.sv
// Two-requester round-robin arbiter sharing one adder; per-requester accumulators.
module adder_share_arb
    import adder_share_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_sum,
    output logic             resp_carry
);

    state_t           state_q;
    req_id_t          rr_ptr_q;
    req_id_t          id_q;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc0_q;
    logic [WIDTH-1:0] acc1_q;
    logic             resp_valid_q;
    req_id_t          resp_id_q;
    logic [WIDTH-1:0] resp_sum_q;
    logic             resp_carry_q;

    req_id_t          grant_c;
    logic             accept_c;
    logic [WIDTH-1:0] acc_sel_c;
    logic [WIDTH-1:0] sum_c;
    logic             carry_c;
    logic             acc_we_c;
    logic [WIDTH-1:0] acc_next_c;

    // Grant a lone requester outright; on contention the round-robin pointer decides.
    always_comb begin
        grant_c = rr_ptr_q;
        if (req0_valid && !req1_valid) begin
            grant_c = 1'b0;
        end else if (req1_valid && !req0_valid) begin
            grant_c = 1'b1;
        end
    end

    assign accept_c   = (state_q == IDLE) && (req0_valid || req1_valid);
    assign req0_ready = (state_q == IDLE) && req0_valid && (grant_c == 1'b0);
    assign req1_ready = (state_q == IDLE) && req1_valid && (grant_c == 1'b1);

    assign acc_sel_c  = id_q ? acc1_q : acc0_q;

    add_unit #(
        .WIDTH (WIDTH)
    ) u_add_unit (
        .op_i       (op_q),
        .a_i        (a_q),
        .b_i        (b_q),
        .acc_i      (acc_sel_c),
        .sum_o      (sum_c),
        .carry_o    (carry_c),
        .acc_we_o   (acc_we_c),
        .acc_next_o (acc_next_c)
    );

    // Sequencer: latch request in IDLE, compute in EXEC, hold result in RESP until taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            rr_ptr_q     <= 1'b0;
            id_q         <= 1'b0;
            op_q         <= OP_ADD;
            a_q          <= '0;
            b_q          <= '0;
            acc0_q       <= '0;
            acc1_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= 1'b0;
            resp_sum_q   <= '0;
            resp_carry_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_c) begin
                        id_q    <= grant_c;
                        op_q    <= grant_c ? req1_op : req0_op;
                        a_q     <= grant_c ? req1_a  : req0_a;
                        b_q     <= grant_c ? req1_b  : req0_b;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    resp_sum_q   <= sum_c;
                    resp_carry_q <= carry_c;
                    resp_id_q    <= id_q;
                    resp_valid_q <= 1'b1;
                    rr_ptr_q     <= ~id_q;
                    if (acc_we_c) begin
                        if (id_q) begin
                            acc1_q <= acc_next_c;
                        end else begin
                            acc0_q <= acc_next_c;
                        end
                    end
                    state_q <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_sum   = resp_sum_q;
    assign resp_carry = resp_carry_q;

endmodule
